// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: FSM encodings, widths, magnitude helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which the unsigned core handles.
  function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on a 33-bit partial remainder; purely combinational.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_in,
  input  logic                 dvd_bit,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   rem_out,
  output logic                 q_bit
);

  logic [DIV_WIDTH+1:0] shifted;

  // One extra bit keeps the compare exact even when the remainder carries into bit 32 (divisor 0).
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? (DIV_WIDTH+1)'(shifted - {2'b00, divisor}) : (DIV_WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/iter_div.sv
// Iterative 32-bit signed/unsigned divider: result_valid 34 cycles after acceptance, held until result_ready.
// ITER_DIV_ZERO_FAST_EN: divisor=0 bypasses the iteration and completes 1 cycle after acceptance.
module iter_div
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 cancel,
  output logic                 ready,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);

  div_state_t           state, next_state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_WIDTH:0]   rem_work;
  logic [DIV_WIDTH:0]   rem_nxt;
  logic [DIV_WIDTH-1:0] q_work;
  logic [DIV_WIDTH-1:0] dsr;
  logic                 q_bit;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;

  assign div_zero     = (divisor == '0);
  assign ready        = (state == IDLE);
  assign result_valid = (state == DONE);

  div_step u_step (
    .rem_in  (rem_work),
    .dvd_bit (q_work[DIV_WIDTH-1]),
    .divisor (dsr),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef ITER_DIV_ZERO_FAST_EN
          next_state = div_zero ? DONE : BUSY;
`else
          next_state = BUSY;
`endif
        end
      end
      BUSY:    if (cnt == '1) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (cancel) next_state = IDLE;
  end

  // The quotient register doubles as the dividend shifter: its MSB feeds each step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      rem_work  <= '0;
      q_work    <= '0;
      dsr       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            rem_work <= '0;
            q_work   <= mag(dividend, signed_op);
            dsr      <= mag(divisor, signed_op);
            // Divide-by-zero keeps the all-ones quotient; remainder sign fix restores the dividend.
            neg_q    <= signed_op & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]) & ~div_zero;
            neg_r    <= signed_op & dividend[DIV_WIDTH-1];
`ifdef ITER_DIV_ZERO_FAST_EN
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end
`endif
          end
        end
        BUSY: begin
          cnt      <= cnt + 1'b1;
          rem_work <= rem_nxt;
          q_work   <= {q_work[DIV_WIDTH-2:0], q_bit};
        end
        FIX: begin
          quotient  <= neg_q ? -q_work : q_work;
          remainder <= neg_r ? -rem_work[DIV_WIDTH-1:0] : rem_work[DIV_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed + randomized scoreboard bench for iter_div; outputs sampled on the falling edge.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        ready;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  always #5 clk = ~clk;

  iter_div dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .ready        (ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef ITER_DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request, wait for its result, hold result_ready low for 'hold' cycles, then handshake.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q_exp, input logic [31:0] r_exp, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    e.q   = q_exp;
    e.r   = r_exp;
    e.lat = (b == 32'd0) ? ZERO_LAT : 34;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      // A start during BUSY must be ignored.
      start    = (n == 5);
      dividend = 32'd5;
      divisor  = 32'd1;
      if (result_valid) break;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, ":valid"}, {31'd0, result_valid}, 32'd1);
    if (!result_valid) return;
    chk({tag, ":latency"}, n, e.lat);
    chk({tag, ":quotient"}, quotient, e.q);
    chk({tag, ":remainder"}, remainder, e.r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_q"}, quotient, e.q);
      chk({tag, ":hold_r"}, remainder, e.r);
      chk({tag, ":hold_valid"}, {31'd0, result_valid}, 32'd1);
      chk({tag, ":hold_ready"}, {31'd0, ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, ":idle_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, ":idle_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, ":kept_q"}, quotient, e.q);
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic        s;
    logic        seen;

    resetn       = 1'b0;
    start        = 1'b0;
    signed_op    = 1'b0;
    dividend     = '0;
    divisor      = '0;
    cancel       = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst:ready", {31'd0, ready}, 32'd1);
    chk("rst:valid", {31'd0, result_valid}, 32'd0);
    chk("rst:quotient", quotient, 32'd0);
    chk("rst:remainder", remainder, 32'd0);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    run_op("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 0);
    run_op("div_by0", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2);
    run_op("div_neg_by0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0);
    run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_small", 1'b0, 32'd3, 32'hFFFF_FFF0, 32'd0, 32'd3, 0);

    // Cancel in BUSY cycle 10 together with a fresh start.
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("cancel:busy_ready", {31'd0, ready}, 32'd0);
    cancel   = 1'b1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    chk("cancel:ready", {31'd0, ready}, 32'd1);
    chk("cancel:valid", {31'd0, result_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid || !ready) seen = 1'b1;
    end
    chk("cancel:no_result", {31'd0, seen}, 32'd0);
    run_op("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Reset mid-operation discards the work.
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b1;
    dividend  = 32'hFFFF_FF00;
    divisor   = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst:ready", {31'd0, ready}, 32'd1);
    chk("midrst:valid", {31'd0, result_valid}, 32'd0);
    chk("midrst:quotient", quotient, 32'd0);
    chk("midrst:remainder", remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    for (int i = 0; i < 10; i++) begin
      s = 1'(i & 1);
      a = $urandom;
      b = (i < 5) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 4) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      ref_div(s, a, b, q, r);
      run_op($sformatf("rand%0d", i), s, a, b, q, r, $urandom_range(0, 2));
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL: start  input  1  request valid; accepted only when ready=1.
REQ-004 SHALL: signed_op  input  1  1=signed DIV, 0=unsigned DIVU; sampled at acceptance.
REQ-005 SHALL: dividend  input  32  numerator; sampled at acceptance.
REQ-006 SHALL: divisor  input  32  denominator; sampled at acceptance.
REQ-007 SHALL: cancel  input  1  abort current operation (pipeline flush/exception).
REQ-008 SHALL: ready  output  1  block is IDLE and can accept start.
REQ-009 SHALL: result_valid  output  1  quotient/remainder valid.
REQ-010 SHALL: result_ready  input  1  consumer accepts result.
REQ-011 SHALL: quotient  output  32  result quotient.
REQ-012 SHALL: remainder  output  32  result remainder.

Function
REQ-013 SHALL implement the states IDLE, BUSY, FIX, DONE as a single FSM.
REQ-014 SHALL, in IDLE with start=1 and cancel=0, latch the operands and signed_op, take magnitudes when signed_op=1, and go to BUSY.
REQ-015 SHALL perform one restoring shift-subtract step per BUSY cycle using a 33-bit partial remainder, with exactly 32 BUSY cycles counted by a 5-bit counter that wraps 31->0 and triggers the exit to FIX.
REQ-016 SHALL apply sign correction in FIX: negate the quotient when the operand signs differ, and give the remainder the sign of the dividend; then go to DONE.
REQ-017 SHALL raise result_valid in DONE, 34 cycles after the acceptance edge.
REQ-018 SHALL hold quotient, remainder, and result_valid stable while result_valid=1 and result_ready=0.
REQ-019 SHALL return to IDLE on the edge where result_valid=1 and result_ready=1, with ready=1 the following cycle and no back-to-back acceptance in DONE.
REQ-020 SHALL keep ready=0 in BUSY, FIX, and DONE; start SHALL be ignored in those states.
REQ-021 SHALL, on cancel=1 in any state, go to IDLE on the next edge with result_valid=0 and no result; cancel SHALL win over a simultaneous start.
REQ-022 SHALL produce quotient=0x80000000 and remainder=0 for signed 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-023 SHALL produce quotient=0xFFFFFFFF and remainder=dividend for divisor=0 (signed or unsigned), with sign correction suppressed.
REQ-024 SHALL NOT change quotient or remainder outputs except on entry to DONE.

Reset
REQ-025 SHALL, on resetn=0, asynchronously force state=IDLE, ready=1 after release, result_valid=0, quotient=0, remainder=0, counter=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard the operation without a result, and the first start after release SHALL behave as from power-up.

Configuration
REQ-027 SHALL, with ITER_DIV_ZERO_FAST_EN defined, detect divisor=0 at acceptance, go directly to DONE, and assert result_valid 1 cycle after acceptance with the REQ-023 values.
REQ-028 SHALL, with ITER_DIV_ZERO_FAST_EN undefined, run divisor=0 through the full 34-cycle path with the identical REQ-023 values.

Structure
REQ-029 SHALL place the FSM state encodings, DIV_WIDTH=32, and DIV_CNT_W=5 in shared package div_pkg.
REQ-030 SHALL isolate the 33-bit compare/subtract/quotient-bit logic in one combinational sub-module, div_step, instantiated once.

Verification
REQ-031 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, result_valid at cycle 34.
REQ-032 SHALL cover: signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-033 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-034 SHALL cover: 0x1234/0 -> quotient=0xFFFFFFFF, remainder=0x1234, at cycle 1 with the macro and cycle 34 without.
REQ-035 SHALL cover: cancel at BUSY cycle 10 plus a simultaneous start -> no result_valid, ready=1 next cycle; the next 9/3 request -> quotient=3, remainder=0.
REQ-036 SHALL cover: result_ready held 0 for 5 cycles in DONE -> outputs stable, ready=0 throughout; IDLE one cycle after the handshake.
